// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_if
//   Bundles every non-clock/reset signal of alu_issue_stage: the ID-side
//   issue handshake and operands, the flush strobe, the ALU_32 drive/return
//   wires, and the MEM-side result handshake.
//   Ports (all carried as interface signals):
//     issue_valid/issue_ready   ID -> stage op handshake
//     alu_op, funct             decode inputs
//     rs_data, rt_data, imm_ext operands, alu_src right-operand select
//     flush                     kill all in-flight ops
//     ALU_Operation, in_left, in_right   stage -> ALU_32
//     Zero, ALU_Result                    ALU_32 -> stage (combinational)
//     res_valid/res_ready       result handshake
//     res_data, res_zero, res_illegal, retire_count   registered results
//   Modports: slave = the stage itself, master = whoever drives it.
// ---------------------------------------------------------------------------
interface alu_issue_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm_ext;
  logic             alu_src;
  logic             flush;
  logic [3:0]       ALU_Operation;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;
  logic             Zero;
  logic [WIDTH-1:0] ALU_Result;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_illegal;
  logic [CNT_W-1:0] retire_count;

  modport slave (
    input  issue_valid, alu_op, funct, rs_data, rt_data, imm_ext, alu_src,
           flush, Zero, ALU_Result, res_ready,
    output issue_ready, ALU_Operation, in_left, in_right, res_valid,
           res_data, res_zero, res_illegal, retire_count
  );

  modport master (
    output issue_valid, alu_op, funct, rs_data, rt_data, imm_ext, alu_src,
           flush, Zero, ALU_Result, res_ready,
    input  issue_ready, ALU_Operation, in_left, in_right, res_valid,
           res_data, res_zero, res_illegal, retire_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Issue/result wrapper around an externally instantiated ALU_32.
//   X stage: captures the decoded 4-bit ALU operation code, the left operand
//   and the selected right operand; its registers drive ALU_32 directly and
//   read as zero whenever X is empty.
//   R stage: captures ALU_32's combinational Zero/ALU_Result when X advances
//   (forced to zero with an illegal flag for undecodable ops) and presents
//   them to MEM with a valid/ready handshake.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; overrides flush and all handshakes
//     bus    alu_issue_stage_if.slave (issue side, ALU_32 side, result side)
//   Parameters:
//     WIDTH  datapath width
//     CNT_W  retire counter width (wraps modulo 2^CNT_W)
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_stage_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  // Returns {illegal, code}. Undecodable ops yield code 0 with illegal set.
  function automatic logic [4:0] decode_op(input logic [1:0] alu_op,
                                           input logic [5:0] funct);
    logic [4:0] d;
    d = {1'b1, 4'd0};
    case (alu_op)
      2'b00: d = {1'b0, OP_ADD};
      2'b01: d = {1'b0, OP_SUB};
      2'b10: begin
        case (funct)
          6'b100000: d = {1'b0, OP_ADD};
          6'b100010: d = {1'b0, OP_SUB};
          6'b100100: d = {1'b0, OP_AND};
          6'b100101: d = {1'b0, OP_OR};
          6'b101010: d = {1'b0, OP_SLT};
          6'b100111: d = {1'b0, OP_NOR};
          default:   d = {1'b1, 4'd0};
        endcase
      end
      default: d = {1'b1, 4'd0};
    endcase
    return d;
  endfunction

  // Handshake / decode wires
  logic             r_load_s;
  logic             x_adv_s;
  logic             issue_ready_s;
  logic             accept_s;
  logic [4:0]       dec_s;
  logic [WIDTH-1:0] right_sel_s;

  // X stage registers
  logic             x_valid_r;
  logic             x_illegal_r;
  logic [3:0]       x_code_r;
  logic [WIDTH-1:0] x_left_r;
  logic [WIDTH-1:0] x_right_r;

  // R stage registers
  logic             res_valid_r;
  logic [WIDTH-1:0] res_data_r;
  logic             res_zero_r;
  logic             res_illegal_r;
  logic [CNT_W-1:0] retire_count_r;

  // Pipeline handshake, decode and right-operand select for the incoming op.
  always_comb begin
    r_load_s      = ~res_valid_r | bus.res_ready;
    x_adv_s       = x_valid_r & r_load_s;
    // No skid buffer: X can take a new op only if it is empty or draining now.
    issue_ready_s = ~bus.flush & (~x_valid_r | x_adv_s);
    accept_s      = bus.issue_valid & issue_ready_s;
    dec_s         = decode_op(bus.alu_op, bus.funct);
    if (bus.alu_src) begin
      right_sel_s = bus.imm_ext;
    end else begin
      right_sel_s = bus.rt_data;
    end
  end

  // X stage: load on accept, clear to zero when it empties so the ALU drive
  // wires are zero whenever X holds nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_valid_r   <= 1'b0;
      x_illegal_r <= 1'b0;
      x_code_r    <= 4'd0;
      x_left_r    <= {WIDTH{1'b0}};
      x_right_r   <= {WIDTH{1'b0}};
    end else if (bus.flush) begin
      x_valid_r   <= 1'b0;
      x_illegal_r <= 1'b0;
      x_code_r    <= 4'd0;
      x_left_r    <= {WIDTH{1'b0}};
      x_right_r   <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      x_valid_r   <= 1'b1;
      x_illegal_r <= dec_s[4];
      x_code_r    <= dec_s[3:0];
      x_left_r    <= bus.rs_data;
      x_right_r   <= right_sel_s;
    end else if (x_adv_s) begin
      x_valid_r   <= 1'b0;
      x_illegal_r <= 1'b0;
      x_code_r    <= 4'd0;
      x_left_r    <= {WIDTH{1'b0}};
      x_right_r   <= {WIDTH{1'b0}};
    end
  end

  // R stage: capture the ALU return when X advances; drop valid on a retire
  // that is not refilled; hold everything while blocked.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_r   <= 1'b0;
      res_data_r    <= {WIDTH{1'b0}};
      res_zero_r    <= 1'b0;
      res_illegal_r <= 1'b0;
    end else if (bus.flush) begin
      res_valid_r   <= 1'b0;
    end else if (x_adv_s) begin
      res_valid_r <= 1'b1;
      if (x_illegal_r) begin
        res_data_r    <= {WIDTH{1'b0}};
        res_zero_r    <= 1'b0;
        res_illegal_r <= 1'b1;
      end else begin
        res_data_r    <= bus.ALU_Result;
        res_zero_r    <= bus.Zero;
        res_illegal_r <= 1'b0;
      end
    end else if (bus.res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

  // Retire counter: counts consumed results, including one consumed in a
  // flush cycle; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count_r <= {CNT_W{1'b0}};
    end else if (res_valid_r & bus.res_ready) begin
      retire_count_r <= retire_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.issue_ready   = issue_ready_s;
  assign bus.ALU_Operation = x_code_r;
  assign bus.in_left       = x_left_r;
  assign bus.in_right      = x_right_r;
  assign bus.res_valid     = res_valid_r;
  assign bus.res_data      = res_data_r;
  assign bus.res_zero      = res_zero_r;
  assign bus.res_illegal   = res_illegal_r;
  assign bus.retire_count  = retire_count_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();
  alu_issue_stage_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

  alu_issue_stage #(.WIDTH(32), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  alu_issue_stage #(.WIDTH(32), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // ALU_32 stand-in (combinational)
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign bus.ALU_Result  = alu_f(bus.ALU_Operation, bus.in_left, bus.in_right);
  assign bus.Zero        = (bus.ALU_Result == 32'd0);
  assign bus4.ALU_Result = alu_f(bus4.ALU_Operation, bus4.in_left, bus4.in_right);
  assign bus4.Zero       = (bus4.ALU_Result == 32'd0);

  // Narrow-counter instance sees exactly the same stimulus
  assign bus4.issue_valid = bus.issue_valid;
  assign bus4.alu_op      = bus.alu_op;
  assign bus4.funct       = bus.funct;
  assign bus4.rs_data     = bus.rs_data;
  assign bus4.rt_data     = bus.rt_data;
  assign bus4.imm_ext     = bus.imm_ext;
  assign bus4.alu_src     = bus.alu_src;
  assign bus4.flush       = bus.flush;
  assign bus4.res_ready   = bus.res_ready;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [3:0]  code;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
  } op_t;

  op_t         q[$];        // in-flight ops, oldest first
  bit          r_full = 1'b0; // oldest op sits in the result stage
  logic [31:0] n_retired = 32'd0;
  bit          chk_en = 1'b0;
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          ncyc = 0;

  function automatic op_t make_op(input logic [1:0] aop, input logic [5:0] fn,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [31:0] imm, input logic src);
    op_t o;
    o.left = rs;
    o.right = src ? imm : rt;
    o.illegal = 1'b0;
    o.code = 4'd0;
    o.result = 32'd0;
    case (aop)
      2'b00: begin o.code = 4'd2; o.result = o.left + o.right; end
      2'b01: begin o.code = 4'd6; o.result = o.left - o.right; end
      2'b10: begin
        case (fn)
          6'h20: begin o.code = 4'd2;  o.result = o.left + o.right; end
          6'h22: begin o.code = 4'd6;  o.result = o.left - o.right; end
          6'h24: begin o.code = 4'd0;  o.result = o.left & o.right; end
          6'h25: begin o.code = 4'd1;  o.result = o.left | o.right; end
          6'h2A: begin o.code = 4'd7;  o.result = {31'd0, $signed(o.left) < $signed(o.right)}; end
          6'h27: begin o.code = 4'd12; o.result = ~(o.left | o.right); end
          default: o.illegal = 1'b1;
        endcase
      end
      default: o.illegal = 1'b1;
    endcase
    o.zero = o.illegal ? 1'b0 : (o.result == 32'd0);
    return o;
  endfunction

  function automatic bit x_present();
    return q.size() > (r_full ? 1 : 0);
  endfunction

  function automatic bit exp_ready();
    return !bus.flush && (!x_present() || !r_full || bus.res_ready);
  endfunction

  task automatic model_step();
    bit xp;
    bit rdy;
    if (reset) begin
      q.delete();
      r_full = 1'b0;
      n_retired = 32'd0;
      return;
    end
    xp = x_present();
    rdy = exp_ready();
    if (r_full && bus.res_ready) begin
      n_retired = n_retired + 32'd1;
      void'(q.pop_front());
      r_full = 1'b0;
    end
    if (bus.flush) begin
      q.delete();
      r_full = 1'b0;
    end else begin
      if (xp && !r_full) r_full = 1'b1;
      if (bus.issue_valid && rdy)
        q.push_back(make_op(bus.alu_op, bus.funct, bus.rs_data, bus.rt_data, bus.imm_ext, bus.alu_src));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every negedge once out of initial reset
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (chk_en) begin
      op_t xo;
      bit xp;
      xp = x_present();
      if (xp) xo = q[r_full ? 1 : 0];
      chk("issue_ready", bus.issue_ready, exp_ready());
      chk("res_valid", bus.res_valid, r_full);
      chk("alu_operation", bus.ALU_Operation, xp ? xo.code : 4'd0);
      chk("in_left", bus.in_left, xp ? xo.left : 32'd0);
      chk("in_right", bus.in_right, xp ? xo.right : 32'd0);
      chk("retire_count", bus.retire_count, n_retired[15:0]);
      chk("retire_count_w4", bus4.retire_count, n_retired[3:0]);
      chk("res_valid_w4", bus4.res_valid, r_full);
      if (r_full) begin
        chk("res_data", bus.res_data, q[0].result);
        chk("res_zero", bus.res_zero, q[0].zero);
        chk("res_illegal", bus.res_illegal, q[0].illegal);
      end
      if (bus.res_valid && bus.res_ready) begin
        log_data.push_back(bus.res_data);
        log_cyc.push_back(ncyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic src, input logic rr, input logic fl, output logic acc);
    bus.issue_valid = v;
    bus.alu_op = aop;
    bus.funct = fn;
    bus.rs_data = rs;
    bus.rt_data = rt;
    bus.imm_ext = imm;
    bus.alu_src = src;
    bus.res_ready = rr;
    bus.flush = fl;
    #3;
    acc = v & (bus.issue_ready === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    logic a;
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 6'h00, 32'd0, 32'd0, 32'd0, 1'b0, rr, 1'b0, a);
  endtask

  task automatic send(input logic [1:0] aop, input logic [5:0] fn, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] imm, input logic src);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) drive(1'b1, aop, fn, rs, rt, imm, src, 1'b1, 1'b0, a);
    chk("send_accepted", a, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.issue_valid = 1'b0; bus.alu_op = 2'b00; bus.funct = 6'h00;
    bus.rs_data = 32'd0; bus.rt_data = 32'd0; bus.imm_ext = 32'd0;
    bus.alu_src = 1'b0; bus.res_ready = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [5:0]  b2b_fn[6]  = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
  logic [3:0]  b2b_code[6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
  logic [31:0] b2b_res[6] = '{32'd1, 32'd7, 32'd8, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFF8};
  logic [31:0] bp_res[4]  = '{32'd8, 32'd5, 32'd9, 32'hFFFFFFFF};

  initial begin
    logic a;
    logic [15:0] rc_before;
    do_reset();
    chk_en = 1'b1;

    // reset state
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_alu_op", bus.ALU_Operation, 4'd0);
    chk("rst_in_left", bus.in_left, 32'd0);
    chk("rst_in_right", bus.in_right, 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_zero", bus.res_zero, 1'b0);
    chk("rst_res_illegal", bus.res_illegal, 1'b0);
    chk("rst_retire_count", bus.retire_count, 16'd0);

    // R-type add 3+5
    send(2'b10, 6'h20, 32'd3, 32'd5, 32'd0, 1'b0);
    chk("add_code", bus.ALU_Operation, 4'd2);
    chk("add_left", bus.in_left, 32'd3);
    chk("add_right", bus.in_right, 32'd5);
    idle(1, 1'b1);
    chk("add_code_gone", bus.ALU_Operation, 4'd0);
    chk("add_res_valid", bus.res_valid, 1'b1);
    chk("add_res_data", bus.res_data, 32'd8);
    chk("add_res_zero", bus.res_zero, 1'b0);

    // back-to-back six ops
    do_reset();
    log_data.delete(); log_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      send(2'b10, b2b_fn[i], 32'd3, 32'd5, 32'd0, 1'b0);
      chk("b2b_code", bus.ALU_Operation, b2b_code[i]);
    end
    idle(3, 1'b1);
    chk("b2b_count", log_data.size(), 6);
    for (int i = 0; i < 6 && i < log_data.size(); i++) begin
      chk("b2b_res", log_data[i], b2b_res[i]);
      chk("b2b_consecutive", log_cyc[i] - log_cyc[0], i);
    end
    chk("b2b_retire_count", bus.retire_count, 16'd6);

    // beq-style sub
    send(2'b01, 6'h00, 32'd5, 32'd5, 32'd0, 1'b0);
    chk("beq_code", bus.ALU_Operation, 4'd6);
    idle(1, 1'b1);
    chk("beq_res_data", bus.res_data, 32'd0);
    chk("beq_res_zero", bus.res_zero, 1'b1);

    // lw-style add with immediate
    send(2'b00, 6'h00, 32'd3, 32'd99, 32'd5, 1'b1);
    chk("lw_code", bus.ALU_Operation, 4'd2);
    chk("lw_right", bus.in_right, 32'd5);
    idle(1, 1'b1);
    chk("lw_res_data", bus.res_data, 32'd8);

    // illegal funct and reserved alu_op
    send(2'b10, 6'h00, 32'd3, 32'd5, 32'd0, 1'b0);
    chk("ill_code", bus.ALU_Operation, 4'd0);
    idle(1, 1'b1);
    chk("ill_valid", bus.res_valid, 1'b1);
    chk("ill_flag", bus.res_illegal, 1'b1);
    chk("ill_data", bus.res_data, 32'd0);
    send(2'b11, 6'h20, 32'd3, 32'd5, 32'd0, 1'b0);
    idle(1, 1'b1);
    chk("ill11_flag", bus.res_illegal, 1'b1);
    idle(2, 1'b1);

    // backpressure: res_ready low for 3 cycles, 4 ops offered
    log_data.delete(); log_cyc.delete();
    drive(1'b1, 2'b10, 6'h20, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, a);
    chk("bp_acc1", a, 1'b1);
    drive(1'b1, 2'b10, 6'h22, 32'd9, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, a);
    chk("bp_acc2", a, 1'b1);
    drive(1'b1, 2'b10, 6'h25, 32'd8, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, a);
    chk("bp_acc3_blocked", a, 1'b0);
    chk("bp_hold_data", bus.res_data, 32'd8);
    chk("bp_hold_code", bus.ALU_Operation, 4'd6);
    send(2'b10, 6'h25, 32'd8, 32'd1, 32'd0, 1'b0);
    send(2'b10, 6'h27, 32'd0, 32'd0, 32'd0, 1'b0);
    idle(3, 1'b1);
    chk("bp_count", log_data.size(), 4);
    for (int i = 0; i < 4 && i < log_data.size(); i++) chk("bp_order", log_data[i], bp_res[i]);

    // flush with X and R full
    rc_before = bus.retire_count;
    drive(1'b1, 2'b10, 6'h20, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, a);
    drive(1'b1, 2'b10, 6'h22, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, a);
    drive(1'b1, 2'b10, 6'h24, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, a);
    chk("flush_no_accept", a, 1'b0);
    chk("flush_res_valid", bus.res_valid, 1'b0);
    chk("flush_code", bus.ALU_Operation, 4'd0);
    chk("flush_count", bus.retire_count, rc_before);
    idle(2, 1'b1);
    // flush cycle that also retires
    drive(1'b1, 2'b10, 6'h20, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, a);
    drive(1'b1, 2'b10, 6'h22, 32'd2, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, a);
    drive(1'b0, 2'b00, 6'h00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, a);
    chk("flush_retire_count", bus.retire_count, rc_before + 16'd1);
    chk("flush_retire_valid", bus.res_valid, 1'b0);

    // reset mid-stream with handshakes active
    drive(1'b1, 2'b10, 6'h20, 32'd2, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, a);
    drive(1'b1, 2'b10, 6'h25, 32'd4, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, a);
    reset = 1'b1;
    drive(1'b1, 2'b10, 6'h20, 32'd6, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0, a);
    reset = 1'b0;
    chk("mrst_res_valid", bus.res_valid, 1'b0);
    chk("mrst_code", bus.ALU_Operation, 4'd0);
    chk("mrst_left", bus.in_left, 32'd0);
    chk("mrst_right", bus.in_right, 32'd0);
    chk("mrst_res_data", bus.res_data, 32'd0);
    chk("mrst_res_zero", bus.res_zero, 1'b0);
    chk("mrst_res_illegal", bus.res_illegal, 1'b0);
    chk("mrst_count", bus.retire_count, 16'd0);

    // 17 retires: narrow counter wraps to 1
    do_reset();
    for (int i = 0; i < 17; i++) send(2'b10, 6'h20, i, 32'd1, 32'd0, 1'b0);
    idle(3, 1'b1);
    chk("wrap_count_w4", bus4.retire_count, 4'd1);
    chk("wrap_count_w16", bus.retire_count, 16'd17);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

endmodule
